// File: rtl/mac_feeder.sv
// Dot-product sequencer: clears the MAC, streams len operand pairs into it, and holds the accumulated result.
// Operands reach the MAC 1 cycle after each handshake; the result stays in HOLD until res_ready, and in_ready is high only in FEED.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module mac_feeder #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int LEN_WIDTH  = 8,
  parameter int MAC_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  output logic                  mac_en,
  output logic                  mac_clr,
  input  logic [DATA_WIDTH-1:0] mac_acc,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data
);

  localparam int DRN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, HOLD} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  cnt_inc;
  logic [DRN_W-1:0]      drn_q, drn_d;
  logic [DATA_WIDTH-1:0] mac_a_q, mac_a_d;
  logic [DATA_WIDTH-1:0] mac_b_q, mac_b_d;
  logic                  mac_en_q, mac_en_d;
  logic                  mac_clr_q, mac_clr_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;

  assign cnt_inc = cnt_q + LEN_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      drn_q       <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      drn_q       <= drn_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    drn_d       = drn_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    mac_en_d    = 1'b0;
    mac_clr_d   = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_d     = len;
            cnt_d     = '0;
            mac_clr_d = 1'b1;
            state_d   = FEED;
          end else begin
            // Empty job: skip the MAC entirely and report a zero result.
            res_data_d  = '0;
            res_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end
      end
      FEED: begin
        if (in_valid) begin
          mac_a_d  = in_a;
          mac_b_d  = in_b;
          mac_en_d = 1'b1;
          cnt_d    = cnt_inc;
          if (cnt_inc == len_q) begin
            drn_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Wait out the last mac_en cycle plus the MAC pipeline before sampling.
        if (drn_q == DRN_W'(MAC_LAT)) begin
          res_data_d  = mac_acc;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == FEED);
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_en    = mac_en_q;
  assign mac_clr   = mac_clr_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule
